// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray/binary conversion helpers for the counter and decode stage.
package gray_pkg;
   localparam int MAX_W = 32;
   localparam logic [MAX_W-1:0] ALL_ONES = {MAX_W{1'b1}};
   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction
   // Zero-extended inputs decode correctly at any width because the unused MSBs are zero.
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b[MAX_W-1] = g[MAX_W-1];
      for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
endpackage

// File: rtl/gray_decode_stage.sv
// gray_decode_stage: one-cycle registered Gray-to-binary decode; result holds when no request.
module gray_decode_stage
   import gray_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic [WIDTH-1:0] gray_in,
   output logic             valid_out,
   output logic [WIDTH-1:0] bin_out
);
   logic             valid_d, valid_q;
   logic [WIDTH-1:0] bin_d, bin_q;
   always_comb begin
      valid_d = valid_in;
      bin_d   = valid_in ? WIDTH'(gray2bin(MAX_W'(gray_in))) : bin_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         bin_q   <= '0;
      end else begin
         valid_q <= valid_d;
         bin_q   <= bin_d;
      end
   end
   assign valid_out = valid_q;
   assign bin_out   = bin_q;
endmodule

// File: rtl/gray_code_counter.sv
// gray_code_counter: up/down binary counter with registered Gray output, wrap pulse and
// an independent Gray decode channel. Gray is registered from the next binary value so it never glitches.
module gray_code_counter
   import gray_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             wrap,
   input  logic             dec_valid_in,
   input  logic [WIDTH-1:0] dec_gray_in,
   output logic             dec_valid_out,
   output logic [WIDTH-1:0] dec_bin_out
);
   localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(bin2gray(MAX_W'(RESET_VAL)));
   localparam logic [WIDTH-1:0] TOP_VAL    = ALL_ONES[WIDTH-1:0];
   logic [WIDTH-1:0] bin_d, bin_q, gray_d, gray_q;
   logic             wrap_d, wrap_q;
   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      if (load) begin
         bin_d = load_bin;
      end else if (en) begin
         bin_d  = up_dn ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
         wrap_d = up_dn ? (bin_q == TOP_VAL) : (bin_q == '0);
      end
      gray_d = WIDTH'(bin2gray(MAX_W'(bin_d)));
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q  <= RESET_VAL;
         gray_q <= RESET_GRAY;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end
   assign bin_out  = bin_q;
   assign gray_out = gray_q;
   assign wrap     = wrap_q;
   gray_decode_stage #(.WIDTH(WIDTH)) u_dec (
      .clk      (clk),
      .rst      (rst),
      .valid_in (dec_valid_in),
      .gray_in  (dec_gray_in),
      .valid_out(dec_valid_out),
      .bin_out  (dec_bin_out)
   );
endmodule
